// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: drives a req/gnt/rvalid data bus, extends load data, and times out silent slaves.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MEM_valid_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [2:0]            MEM_funct3_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_rd_data2_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  MEM_stall_o,
  output logic [DATA_WIDTH-1:0] MEM_fwd_data_o,
  output logic [DATA_WIDTH-1:0] MEM_load_data_o,
  output logic                  MEM_load_valid_o,
  output logic                  MEM_bus_err_o,
  output logic                  MEM_misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      tmo_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  load_done_q, bus_err_q, misalign_q;

  logic                  mem_access, trap, timeout_hit, rsp_take;
  logic [1:0]            size, eff_lo;
  logic [DATA_WIDTH-1:0] lane_word, load_ext;

  assign mem_access = MEM_valid_i && (MEM_MemRead_i || MEM_MemWrite_i);
  assign size       = MEM_funct3_i[1:0];

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == 2'b01) && MEM_alu_result_i[0]) ||
                      ((size == 2'b10) && (MEM_alu_result_i[1:0] != 2'b00));
  assign trap   = misaligned;
  assign eff_lo = MEM_alu_result_i[1:0];
`else
  assign trap = 1'b0;
  always_comb begin
    case (size)
      2'b01:   eff_lo = {MEM_alu_result_i[1], 1'b0};
      2'b10:   eff_lo = 2'b00;
      default: eff_lo = MEM_alu_result_i[1:0];
    endcase
  end
`endif

  assign timeout_hit = (state_q == WAIT) && !dmem_rvalid_i &&
                       (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_take    = ((state_q == REQ) && dmem_gnt_i && dmem_rvalid_i) ||
                       ((state_q == WAIT) && dmem_rvalid_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_access) state_d = trap ? DONE : REQ;
      REQ:     if (dmem_gnt_i) state_d = dmem_rvalid_i ? DONE : WAIT;
      WAIT:    if (dmem_rvalid_i || timeout_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Load lane is picked from the (possibly forced-aligned) low address bits.
  assign lane_word = dmem_rdata_i >> {eff_lo, 3'b000};

  always_comb begin
    case (MEM_funct3_i)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane_word[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_word[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      load_data_q <= '0;
      load_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= (state_q == WAIT) ? tmo_q + CNT_W'(1) : '0;
      bus_err_q   <= timeout_hit;
      misalign_q  <= (state_q == IDLE) && mem_access && trap;
      load_done_q <= MEM_MemRead_i && (rsp_take || timeout_hit);
      if (MEM_MemRead_i && rsp_take)
        load_data_q <= load_ext;
      else if (MEM_MemRead_i && timeout_hit)
        load_data_q <= '0;
    end
  end

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = MEM_rd_data2_i;
    if (MEM_MemWrite_i) begin
      case (size)
        2'b00: begin
          dmem_be_o    = 4'b0001 << eff_lo;
          dmem_wdata_o = DATA_WIDTH'({4{MEM_rd_data2_i[7:0]}});
        end
        2'b01: begin
          dmem_be_o    = 4'b0011 << eff_lo;
          dmem_wdata_o = DATA_WIDTH'({2{MEM_rd_data2_i[15:0]}});
        end
        default: ;
      endcase
    end
  end

  assign dmem_req_o  = (state_q == REQ);
  assign dmem_we_o   = MEM_MemWrite_i;
  assign dmem_addr_o = {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};

  // Reset gates the combinational stall so the pipeline is released during reset.
  assign MEM_stall_o = rst_n && (((state_q == IDLE) && mem_access) ||
                                 (state_q == REQ) || (state_q == WAIT));

  assign MEM_load_valid_o = (state_q == DONE) && load_done_q;
  assign MEM_load_data_o  = load_data_q;
  assign MEM_fwd_data_o   = MEM_load_valid_o ? load_data_q : MEM_alu_result_i;
  assign MEM_bus_err_o    = bus_err_q;
  assign MEM_misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit; driver pushes expectations, monitor pops on bus/response events.
module tb_mem_access_unit;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_valid_i, MEM_MemRead_i, MEM_MemWrite_i;
  logic [2:0]  MEM_funct3_i;
  logic [31:0] MEM_alu_result_i, MEM_rd_data2_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        MEM_stall_o, MEM_load_valid_o, MEM_bus_err_o, MEM_misalign_o;
  logic [31:0] MEM_fwd_data_o, MEM_load_data_o;

  int checks = 0;
  int errors = 0;

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic lv; logic [31:0] data; logic err; logic mis; } rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_valid_i(MEM_valid_i), .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i),
    .MEM_funct3_i(MEM_funct3_i), .MEM_alu_result_i(MEM_alu_result_i), .MEM_rd_data2_i(MEM_rd_data2_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .MEM_stall_o(MEM_stall_o), .MEM_fwd_data_o(MEM_fwd_data_o),
    .MEM_load_data_o(MEM_load_data_o), .MEM_load_valid_o(MEM_load_valid_o),
    .MEM_bus_err_o(MEM_bus_err_o), .MEM_misalign_o(MEM_misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on size, byte offset and data.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (off * 8);
    case (f3)
      3'b000:  return ((sh & 32'hFF) >= 32'h80) ? ((sh & 32'hFF) | 32'hFFFFFF00) : (sh & 32'hFF);
      3'b001:  return ((sh & 32'hFFFF) >= 32'h8000) ? ((sh & 32'hFFFF) | 32'hFFFF0000) : (sh & 32'hFFFF);
      3'b100:  return sh & 32'hFF;
      3'b101:  return sh & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  always @(negedge clk) begin
    req_t r;
    rsp_t s;
    if (rst_n) begin
      if (dmem_req_o && dmem_gnt_i) begin
        if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          r = req_q.pop_front();
          chk("we", {31'd0, dmem_we_o}, {31'd0, r.we});
          chk("addr", dmem_addr_o, r.addr);
          chk("be", {28'd0, dmem_be_o}, {28'd0, r.be});
          if (r.we) chk("wdata", dmem_wdata_o, r.wdata);
        end
      end
      if (MEM_load_valid_o || MEM_bus_err_o || MEM_misalign_o) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          s = rsp_q.pop_front();
          chk("load_valid", {31'd0, MEM_load_valid_o}, {31'd0, s.lv});
          chk("bus_err", {31'd0, MEM_bus_err_o}, {31'd0, s.err});
          chk("misalign", {31'd0, MEM_misalign_o}, {31'd0, s.mis});
          if (s.lv) begin
            chk("load_data", MEM_load_data_o, s.data);
            chk("fwd_load", MEM_fwd_data_o, s.data);
          end
        end
      end else begin
        chk("fwd_pass", MEM_fwd_data_o, MEM_alu_result_i);
      end
    end
  end

  task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int gd, input int rd, input bit tmo);
    logic [31:0] eff;
    bit trap, granted, g_prev, done;
    int off, rc, wc, stall_cnt, exp_stall;
    req_t r;
    rsp_t s;
    trap = 1'b0;
    eff  = addr;
`ifdef MISALIGN_TRAP_EN
    trap = ((f3[1:0] == 2'b01) && (addr % 2 != 0)) || ((f3[1:0] == 2'b10) && (addr % 4 != 0));
`else
    if (f3[1:0] == 2'b01) eff = addr & ~32'd1;
    if (f3[1:0] == 2'b10) eff = addr & ~32'd3;
`endif
    off = int'(eff % 4);
    if (!trap) begin
      r.we = !ld;
      r.addr = eff & ~32'd3;
      r.be = 4'hF;
      r.wdata = sdata;
      if (!ld && f3[1:0] == 2'b00) begin r.be = 4'b0001 << off; r.wdata = (sdata & 32'hFF) * 32'h01010101; end
      if (!ld && f3[1:0] == 2'b01) begin r.be = 4'b0011 << off; r.wdata = (sdata & 32'hFFFF) * 32'h00010001; end
      req_q.push_back(r);
    end
    s.lv = ld && !trap; s.err = tmo && !trap; s.mis = trap;
    s.data = tmo ? 32'd0 : model_load(f3, off, rdata);
    if (s.lv || s.err || s.mis) rsp_q.push_back(s);
    exp_stall = trap ? 1 : 2 + gd + (tmo ? TMO : rd);

    @(posedge clk); #1;
    MEM_valid_i = 1'b1; MEM_MemRead_i = ld; MEM_MemWrite_i = !ld;
    MEM_funct3_i = f3; MEM_alu_result_i = addr; MEM_rd_data2_i = sdata; dmem_rdata_i = rdata;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    granted = 0; rc = 0; wc = 0; stall_cnt = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!MEM_stall_o) done = 1;
      else begin
        stall_cnt++;
        @(posedge clk); #1;
        g_prev = dmem_gnt_i;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        if (g_prev) granted = 1;
        if (dmem_req_o) begin
          if (rc == gd) begin dmem_gnt_i = 1'b1; dmem_rvalid_i = !tmo && rd == 0; end
          rc++;
        end else if (granted) begin
          wc++;
          if (!tmo && wc == rd) dmem_rvalid_i = 1'b1;
        end
      end
    end
    if (!done) chk("stall_release_timeout", 32'd0, 32'd1);
    else chk("stall_cycles", stall_cnt, exp_stall);
    @(posedge clk); #1;
    MEM_valid_i = 1'b0; MEM_MemRead_i = 1'b0; MEM_MemWrite_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, dmem_req_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, MEM_stall_o}, 32'd0);
    chk({tag, "_lv"}, {31'd0, MEM_load_valid_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, MEM_bus_err_o}, 32'd0);
    chk({tag, "_mis"}, {31'd0, MEM_misalign_o}, 32'd0);
    chk({tag, "_ldata"}, MEM_load_data_o, 32'd0);
  endtask

  initial begin
    logic [2:0] lf3 [5];
    logic [2:0] f3;
    bit ld;
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
    rst_n = 1'b0; MEM_valid_i = 1'b0; MEM_MemRead_i = 1'b0; MEM_MemWrite_i = 1'b0;
    MEM_funct3_i = 3'b010; MEM_alu_result_i = 32'h0; MEM_rd_data2_i = 32'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("reset");
    rst_n = 1'b1;

    do_access(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0);
    do_access(1, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 1, 0);
    do_access(1, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0, 0);
    do_access(1, 3'b001, 32'h102, 32'h0, 32'h80112233, 2, 3, 0);
    do_access(0, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0, 1, 0);
    do_access(1, 3'b010, 32'h200, 32'h0, 32'h12345678, 0, 0, 1);
    do_access(1, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1, 0);
    do_access(0, 3'b001, 32'h303, 32'h0000BEEF, 32'h0, 1, 2, 0);

    for (int i = 0; i < 40; i++) begin
      ld = $urandom_range(1, 0) == 1;
      f3 = ld ? lf3[$urandom_range(4, 0)] : 3'($urandom_range(2, 0));
      do_access(ld, f3, $urandom, $urandom, $urandom, int'($urandom_range(3, 0)),
                int'($urandom_range(4, 0)), $urandom_range(19, 0) == 0);
    end

    // Reset while waiting for the response; the late rvalid must be ignored.
    r_q_push_reset_case();
    @(posedge clk); #1;
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic r_q_push_reset_case();
    req_t r;
    r.we = 1'b0; r.addr = 32'h400; r.be = 4'hF; r.wdata = 32'h0;
    req_q.push_back(r);
    @(posedge clk); #1;
    MEM_valid_i = 1'b1; MEM_MemRead_i = 1'b1; MEM_funct3_i = 3'b010;
    MEM_alu_result_i = 32'h400; dmem_rdata_i = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("rst_case_req", {31'd0, dmem_req_o}, 32'd1);
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    MEM_valid_i = 1'b0; MEM_MemRead_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid_i = 1'b1;
    @(negedge clk);
    chk_idle_outputs("late_rvalid");
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_late_rvalid");
  endtask

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32 (from defines), as the datapath and bus data width.
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 16, as the maximum cycles spent in WAIT before a bus error.
REQ-003 Ports SHALL be:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
MEM_valid_i  in  1  EX/MEM slot holds a live instruction.
MEM_MemRead_i  in  1  load.
MEM_MemWrite_i  in  1  store.
MEM_funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
MEM_alu_result_i  in  DATA_WIDTH  EX result; effective address for loads and stores.
MEM_rd_data2_i  in  DATA_WIDTH  store data, already forwarded.
dmem_req_o  out  1  request valid.
dmem_we_o  out  1  write request.
dmem_addr_o  out  DATA_WIDTH  word-aligned address.
dmem_be_o  out  4  byte enables.
dmem_wdata_o  out  DATA_WIDTH  lane-positioned store data.
dmem_gnt_i  in  1  request accepted.
dmem_rvalid_i  in  1  response (read data or write acknowledge).
dmem_rdata_i  in  DATA_WIDTH  read word.
MEM_stall_o  out  1  freeze IF..MEM.
MEM_fwd_data_o  out  DATA_WIDTH  value forwarded to EX (MEM_alu_result_i input of the EX forward muxes).
MEM_load_data_o  out  DATA_WIDTH  extended load result toward MEM/WB.
MEM_load_valid_o  out  1  load result valid, one cycle.
MEM_bus_err_o  out  1  timeout pulse, one cycle.
MEM_misalign_o  out  1  misaligned access pulse (macro-dependent).

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-005 IDLE->REQ when MEM_valid_i && (MEM_MemRead_i || MEM_MemWrite_i) and the access is accepted per REQ-016; otherwise stay IDLE.
REQ-006 REQ: dmem_req_o=1 with addr/be/we/wdata held stable; REQ->WAIT on dmem_gnt_i=1; gnt and rvalid in the same cycle SHALL go directly to DONE.
REQ-007 WAIT: dmem_req_o=0; WAIT->DONE on dmem_rvalid_i=1; after TIMEOUT_CYCLES cycles without rvalid, WAIT->DONE with MEM_bus_err_o pulsed and load data 0.
REQ-008 DONE: MEM_stall_o=0 for exactly one cycle; DONE->IDLE unconditionally; no request is launched from DONE.
REQ-009 MEM_stall_o SHALL be combinational: 1 in IDLE when a memory access is present, 1 in REQ and WAIT, 0 otherwise.
REQ-010 dmem_addr_o SHALL be {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00}.
REQ-011 Stores: B be=4'b0001<<addr[1:0], wdata=byte replicated x4; H be=4'b0011<<addr[1:0], wdata=half replicated x2; W be=4'b1111.
REQ-012 Loads: dmem_be_o=4'b1111; lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W passed through; result registered on rvalid.
REQ-013 MEM_load_valid_o SHALL pulse 1 in DONE for loads only, never for stores.
REQ-014 MEM_fwd_data_o SHALL equal MEM_load_data_o in DONE of a load, else MEM_alu_result_i.
REQ-015 A store SHALL complete only on dmem_rvalid_i (write acknowledge), same path as loads.

Reset
REQ-017 Asserting rst_n low SHALL immediately force IDLE, clear the timeout counter, and drive dmem_req_o, MEM_stall_o, MEM_load_valid_o, MEM_bus_err_o, MEM_misalign_o to 0 and MEM_load_data_o to 0, including mid-transaction; a late rvalid after reset SHALL be ignored.

Configuration
REQ-016 With MISALIGN_TRAP_EN defined, H with addr[0]=1 or W with addr[1:0]!=0 SHALL not issue a request, SHALL pulse MEM_misalign_o for one cycle and pass through IDLE->DONE; without it, MEM_misalign_o SHALL be tied 0 and low address bits SHALL be forced to natural alignment (H clears bit 0, W clears bits 1:0).

Verification
REQ-018 LW addr 0x100, gnt cycle 1, rvalid cycle 3 rdata 0xDEADBEEF -> stall high 4 cycles, load_data 0xDEADBEEF, load_valid one pulse.
REQ-019 LB addr 0x103, rdata 0x80112233 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
REQ-020 SB addr 0x101 data 0x000000AB -> be 4'b0010, wdata 0xABABABAB, we=1, no load_valid.
REQ-021 LW with rvalid withheld -> after 16 WAIT cycles bus_err pulse, load_data 0, stall released in DONE.
REQ-022 rst_n low while in WAIT, then rvalid -> outputs zero, FSM IDLE, no load_valid.
REQ-023 With MISALIGN_TRAP_EN, LW addr 0x102 -> no dmem_req_o, MEM_misalign_o one pulse; without it -> request at 0x100, be 4'b1111.
